ahb_gpio_master: RTL and testbench

AHB-lite single-master initiator that drives the GPIO peripheral's slave port. Command-side logic (bench sequencer or CPU-side shim) issues simple read/write commands over a valid/ready handshake. The block converts each command into a non-pipelined AHB-lite single transfer, generates the GPIO parity bit on writes, checks parity on reads, and returns a response with read data, a parity-error flag and a wait-state count.

---
 rtl/ahb_gpio_master.sv | 157 +++++++++++++++
 tb/tb_ahb_gpio_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_gpio_master.sv
// AHB-lite single-master initiator for the GPIO slave port: one non-pipelined
// transfer per command, parity generated on writes and checked on reads.
module ahb_gpio_master #(
  parameter int WAIT_W = 8,
  parameter int GPIO_W = 16
) (
  input  logic              clk,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [31:0]       cmd_addr,
  input  logic [GPIO_W-1:0] cmd_wdata,
  input  logic              cmd_parsel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [GPIO_W-1:0] rsp_rdata,
  output logic              rsp_parerr,
  output logic [WAIT_W-1:0] rsp_waits,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic              HSEL,
  output logic              HREADY,
  output logic [31:0]       HWDATA,
  output logic              PARITYSEL,
  input  logic [31:0]       HRDATA,
  input  logic              HREADYOUT
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam int         PAD_W        = 31 - GPIO_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic              r_write;
  logic [31:0]       r_addr;
  logic [GPIO_W-1:0] r_wdata;
  logic              r_parsel;
  logic [WAIT_W-1:0] r_waits;
  logic [GPIO_W-1:0] r_rdata;
  logic              r_parerr;
  logic [31:0]       r_hwdata;

  logic w_accept;
  logic w_wrParity;
  logic w_rdParityExp;
  logic w_rdParityErr;
  logic w_unused;

  assign w_accept      = (r_state == S_IDLE) && cmd_valid;
  // Odd parity is the inverse of the even reduction, so parsel simply flips it.
  assign w_wrParity    = (^r_wdata) ^ r_parsel;
  assign w_rdParityExp = (^HRDATA[GPIO_W-1:0]) ^ r_parsel;
  assign w_rdParityErr = HRDATA[GPIO_W] ^ w_rdParityExp;
  assign w_unused      = ^{HRDATA[31:GPIO_W+1], cmd_addr[1:0]};

  always_ff @(posedge clk or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    HTRANS      = TRANS_IDLE;
    HSEL        = 1'b0;
    HWRITE      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_nextState = S_ADDR;
        end
      end
      S_ADDR: begin
        HTRANS = TRANS_NONSEQ;
        HSEL   = 1'b1;
        HWRITE = r_write;
        if (HREADYOUT) begin
          w_nextState = S_DATA;
        end
      end
      S_DATA: begin
        if (HREADYOUT) begin
          w_nextState = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Command capture, write-data launch, wait counting and response capture.
  always_ff @(posedge clk or posedge HRESET) begin
    if (HRESET) begin
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_parsel <= 1'b0;
      r_waits  <= '0;
      r_rdata  <= '0;
      r_parerr <= 1'b0;
      r_hwdata <= '0;
    end else begin
      if (w_accept) begin
        r_write  <= cmd_write;
        r_addr   <= {cmd_addr[31:2], 2'b00};
        r_wdata  <= cmd_wdata;
        r_parsel <= cmd_parsel;
        r_waits  <= '0;
      end
      if ((r_state == S_ADDR) && HREADYOUT && r_write) begin
        r_hwdata <= {{PAD_W{1'b0}}, w_wrParity, r_wdata};
      end
      if (r_state == S_DATA) begin
        if (!HREADYOUT) begin
          if (r_waits != {WAIT_W{1'b1}}) begin
            r_waits <= r_waits + WAIT_W'(1);
          end
        end else begin
          r_rdata  <= r_write ? '0 : HRDATA[GPIO_W-1:0];
          r_parerr <= !r_write && w_rdParityErr;
        end
      end
    end
  end

  assign HADDR      = r_addr;
  assign HWDATA     = r_hwdata;
  assign HREADY     = HREADYOUT;
  assign PARITYSEL  = r_parsel && (r_state != S_IDLE);
  assign rsp_rdata  = r_rdata;
  assign rsp_parerr = r_parerr;
  assign rsp_waits  = r_waits;

endmodule

// File: tb/tb_ahb_gpio_master.sv
// Directed bench for ahb_gpio_master: a table of single transfers with
// hand-computed bus and response values, plus back-pressure and reset-abort runs.
module tb_ahb_gpio_master;

  logic        clk = 1'b0;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_parsel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_parerr;
  logic [7:0]  rsp_waits;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        PARITYSEL;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  int total = 0;
  int bad   = 0;
  logic [31:0] prevHw;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic        parsel;
    int          addrWaits;
    int          dataWaits;
    logic [31:0] hrdata;
    logic [31:0] expAddr;
    logic [31:0] expHwdata;
    logic [15:0] expRdata;
    logic        expParerr;
    logic [7:0]  expWaits;
  } vec_t;

  vec_t vecs[9];

  ahb_gpio_master #(.WAIT_W(8), .GPIO_W(16)) dut (
    .clk        (clk),
    .HRESET     (HRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_parsel (cmd_parsel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_parerr (rsp_parerr),
    .rsp_waits  (rsp_waits),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSEL       (HSEL),
    .HREADY     (HREADY),
    .HWDATA     (HWDATA),
    .PARITYSEL  (PARITYSEL),
    .HRDATA     (HRDATA),
    .HREADYOUT  (HREADYOUT)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one transfer starting just after a negedge; leaves the block in RESP if holdResp.
  task automatic applyStimulus(input vec_t v, input int idx, input bit holdResp);
    logic [31:0] expHw;
    cmd_write  = v.write;
    cmd_addr   = v.addr;
    cmd_wdata  = v.wdata;
    cmd_parsel = v.parsel;
    cmd_valid  = 1'b1;
    HREADYOUT  = 1'b1;
    checkOutput($sformatf("v%0d_cmd_ready_idle", idx), 32'(cmd_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput($sformatf("v%0d_htrans_addr", idx), 32'(HTRANS), 32'h2);
    checkOutput($sformatf("v%0d_hsel_addr", idx), 32'(HSEL), 32'd1);
    checkOutput($sformatf("v%0d_haddr", idx), HADDR, v.expAddr);
    checkOutput($sformatf("v%0d_hwrite", idx), 32'(HWRITE), 32'(v.write));
    checkOutput($sformatf("v%0d_paritysel_addr", idx), 32'(PARITYSEL), 32'(v.parsel));
    checkOutput($sformatf("v%0d_cmd_ready_busy", idx), 32'(cmd_ready), 32'd0);
    HREADYOUT = (v.addrWaits == 0);
    for (int a = 0; a < v.addrWaits; a++) begin
      @(posedge clk); @(negedge clk);
      checkOutput($sformatf("v%0d_htrans_addr_hold", idx), 32'(HTRANS), 32'h2);
      checkOutput($sformatf("v%0d_haddr_hold", idx), HADDR, v.expAddr);
      if (a == v.addrWaits - 1) HREADYOUT = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    expHw = v.write ? v.expHwdata : prevHw;
    prevHw = expHw;
    HRDATA = v.hrdata;
    checkOutput($sformatf("v%0d_htrans_data", idx), 32'(HTRANS), 32'h0);
    checkOutput($sformatf("v%0d_hsel_data", idx), 32'(HSEL), 32'd0);
    checkOutput($sformatf("v%0d_hwrite_data", idx), 32'(HWRITE), 32'd0);
    checkOutput($sformatf("v%0d_hwdata", idx), HWDATA, expHw);
    checkOutput($sformatf("v%0d_paritysel_data", idx), 32'(PARITYSEL), 32'(v.parsel));
    HREADYOUT = (v.dataWaits == 0);
    for (int w = 0; w < v.dataWaits; w++) begin
      @(posedge clk); @(negedge clk);
      if (w < 4) begin
        checkOutput($sformatf("v%0d_hwdata_wait%0d", idx, w), HWDATA, expHw);
        checkOutput($sformatf("v%0d_rsp_valid_wait%0d", idx, w), 32'(rsp_valid), 32'd0);
      end
      if (w == 0) checkOutput($sformatf("v%0d_hready_low", idx), 32'(HREADY), 32'd0);
      if (w == v.dataWaits - 1) HREADYOUT = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    checkOutput($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'd1);
    checkOutput($sformatf("v%0d_rsp_rdata", idx), 32'(rsp_rdata), 32'(v.expRdata));
    checkOutput($sformatf("v%0d_rsp_parerr", idx), 32'(rsp_parerr), 32'(v.expParerr));
    checkOutput($sformatf("v%0d_rsp_waits", idx), 32'(rsp_waits), 32'(v.expWaits));
    checkOutput($sformatf("v%0d_paritysel_resp", idx), 32'(PARITYSEL), 32'(v.parsel));
    checkOutput($sformatf("v%0d_hready_resp", idx), 32'(HREADY), 32'd1);
    if (!holdResp) begin
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput($sformatf("v%0d_rsp_valid_done", idx), 32'(rsp_valid), 32'd0);
      checkOutput($sformatf("v%0d_cmd_ready_done", idx), 32'(cmd_ready), 32'd1);
    end
  endtask

  initial begin
    //           wr    addr          wdata     par  aw dw   hrdata        expAddr       expHwdata     rdata     pe    waits
    vecs[0] = '{1'b1, 32'h5300_0003, 16'h00A5, 1'b0, 0, 0, 32'h0001_FFFF, 32'h5300_0000, 32'h0000_00A5, 16'h0000, 1'b0, 8'd0};
    vecs[1] = '{1'b1, 32'h5300_0004, 16'h00A5, 1'b1, 0, 0, 32'h0000_0000, 32'h5300_0004, 32'h0001_00A5, 16'h0000, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 32'h5300_0008, 16'h5A5A, 1'b0, 0, 3, 32'h0001_1234, 32'h5300_0008, 32'h0000_0000, 16'h1234, 1'b0, 8'd3};
    vecs[3] = '{1'b0, 32'h5300_000B, 16'h5A5A, 1'b0, 0, 3, 32'h0000_1234, 32'h5300_0008, 32'h0000_0000, 16'h1234, 1'b1, 8'd3};
    vecs[4] = '{1'b0, 32'h5300_000C, 16'h0000, 1'b1, 2, 1, 32'h0000_1234, 32'h5300_000C, 32'h0000_0000, 16'h1234, 1'b0, 8'd1};
    vecs[5] = '{1'b1, 32'h5300_0010, 16'hFFFF, 1'b1, 0, 2, 32'h0000_0000, 32'h5300_0010, 32'h0001_FFFF, 16'h0000, 1'b0, 8'd2};
    vecs[6] = '{1'b1, 32'hFFFF_FFFE, 16'h8001, 1'b0, 1, 0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_8001, 16'h0000, 1'b0, 8'd0};
    vecs[7] = '{1'b0, 32'h0000_0001, 16'h0000, 1'b0, 0, 0, 32'hFFFE_0001, 32'h0000_0000, 32'h0000_0000, 16'h0001, 1'b1, 8'd0};
    vecs[8] = '{1'b0, 32'h5300_0014, 16'h0000, 1'b0, 0, 300, 32'h0001_1234, 32'h5300_0014, 32'h0000_0000, 16'h1234, 1'b0, 8'd255};

    HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_parsel = 1'b0; rsp_ready = 1'b0; HRDATA = '0; HREADYOUT = 1'b1;
    prevHw = 32'h0;
    #3;
    checkOutput("reset_htrans", 32'(HTRANS), 32'h0);
    checkOutput("reset_hsel", 32'(HSEL), 32'd0);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("reset_rsp_parerr", 32'(rsp_parerr), 32'd0);
    checkOutput("reset_rsp_waits", 32'(rsp_waits), 32'd0);
    checkOutput("reset_haddr", HADDR, 32'd0);
    checkOutput("reset_hwdata", HWDATA, 32'd0);
    checkOutput("reset_paritysel", 32'(PARITYSEL), 32'd0);
    repeat (2) @(negedge clk);
    HRESET = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], i, 1'b0);
    end

    $display("[TB] back-pressure sequence");
    applyStimulus(vecs[3], 20, 1'b1);
    cmd_write = 1'b1; cmd_addr = 32'h5300_0003; cmd_wdata = 16'h00A5; cmd_parsel = 1'b0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      checkOutput($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("bp%0d_rsp_rdata", c), 32'(rsp_rdata), 32'h1234);
      checkOutput($sformatf("bp%0d_rsp_parerr", c), 32'(rsp_parerr), 32'd1);
      checkOutput($sformatf("bp%0d_rsp_waits", c), 32'(rsp_waits), 32'd3);
      checkOutput($sformatf("bp%0d_cmd_ready", c), 32'(cmd_ready), 32'd0);
      checkOutput($sformatf("bp%0d_htrans", c), 32'(HTRANS), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_release_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("bp_release_htrans", 32'(HTRANS), 32'h0);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("bp_next_htrans", 32'(HTRANS), 32'h2);
    checkOutput("bp_next_haddr", HADDR, 32'h5300_0000);
    @(posedge clk); @(negedge clk);
    checkOutput("bp_next_hwdata", HWDATA, 32'h0000_00A5);
    @(posedge clk); @(negedge clk);
    checkOutput("bp_next_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp_next_rsp_waits", 32'(rsp_waits), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    prevHw = 32'h0000_00A5;

    $display("[TB] reset-abort sequence");
    cmd_write = 1'b0; cmd_addr = 32'h5300_0018; cmd_parsel = 1'b1; cmd_valid = 1'b1;
    HREADYOUT = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("abort_htrans_addr", 32'(HTRANS), 32'h2);
    @(posedge clk); @(negedge clk);
    HREADYOUT = 1'b0;
    checkOutput("abort_paritysel_data", 32'(PARITYSEL), 32'd1);
    @(posedge clk); @(negedge clk);
    checkOutput("abort_waits_before", 32'(rsp_waits), 32'd1);
    #2 HRESET = 1'b1;
    #1;
    checkOutput("abort_htrans", 32'(HTRANS), 32'h0);
    checkOutput("abort_hsel", 32'(HSEL), 32'd0);
    checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_rsp_waits", 32'(rsp_waits), 32'd0);
    checkOutput("abort_rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("abort_hwdata", HWDATA, 32'd0);
    checkOutput("abort_paritysel", 32'(PARITYSEL), 32'd0);
    @(negedge clk);
    HRESET = 1'b0;
    HREADYOUT = 1'b1;
    prevHw = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      checkOutput($sformatf("abort_idle%0d_rsp_valid", c), 32'(rsp_valid), 32'd0);
      checkOutput($sformatf("abort_idle%0d_htrans", c), 32'(HTRANS), 32'h0);
    end
    applyStimulus(vecs[2], 30, 1'b0);
    applyStimulus(vecs[1], 31, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
